// File: rtl/permutation_lane_scheduler_pkg.sv
// Shared constants and types for the permutation lane scheduler.
//   BOT_W        : width of one bot word taken from the input FIFO
//   SERIES_LEN   : permutations applied to each bot (6 x 7 index pairs)
//   PERMUT7_MAX  : start value of the inner (0..6) index
//   PERMUT6_MAX  : start value of the outer (0..5) index
//   lane_state_e : per-lane sequencer state
//   count_lanes  : popcount over up to six lane flags
package permutation_lane_scheduler_pkg;

  localparam int unsigned BOT_W      = 128;
  localparam int unsigned SERIES_LEN = 42;
  localparam logic [2:0]  PERMUT7_MAX = 3'd6;
  // The outer index counts whole passes of the inner index.
  localparam logic [2:0]  PERMUT6_MAX = 3'(SERIES_LEN / (int'(PERMUT7_MAX) + 1) - 1);

  typedef enum logic {
    LaneIdle,
    LaneRun
  } lane_state_e;

  function automatic logic [2:0] count_lanes(input logic [5:0] flags);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) begin
      n = n + {2'b00, flags[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/permutation_lane_sequencer.sv
// One permutation lane: holds the bot being permuted and walks the (permut6, permut7)
// index pairs from (5,6) down to (0,0), one pair per cycle.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   grant_i        : arbiter hands the FIFO head to this lane this cycle
//   slow_down_i    : lane must not accept a new bot (eligibility only)
//   bot_i          : FIFO head data, captured on grant
//   eligible_o     : lane may be granted this cycle
//   active_next_o  : next-state of active_o (for the registered busy count)
//   bot_o          : bot currently permuted (registered)
//   permut6_o/7_o  : current index pair (registered)
//   load_o         : one-cycle pulse with the first index of a new bot
//   active_o       : index/bot valid this cycle
//   done_o         : one-cycle pulse with the final (0,0) index
module permutation_lane_sequencer
  import permutation_lane_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_i,
  input  logic             slow_down_i,
  input  logic [BOT_W-1:0] bot_i,
  output logic             eligible_o,
  output logic             active_next_o,
  output logic [BOT_W-1:0] bot_o,
  output logic [2:0]       permut6_o,
  output logic [2:0]       permut7_o,
  output logic             load_o,
  output logic             active_o,
  output logic             done_o
);

  lane_state_e      state_q;
  logic [2:0]       p6_q;
  logic [2:0]       p7_q;
  logic [BOT_W-1:0] bot_q;
  logic             load_q;
  logic             done_q;
  logic             at_end;

  assign at_end = (state_q == LaneRun) && (p6_q == 3'd0) && (p7_q == 3'd0);

  // A lane on its last index can take the next bot with no gap.
  assign eligible_o    = !slow_down_i && ((state_q == LaneIdle) || at_end);
  assign active_next_o = grant_i || ((state_q == LaneRun) && !at_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LaneIdle;
      p6_q    <= 3'd0;
      p7_q    <= 3'd0;
      bot_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (grant_i) begin
        state_q <= LaneRun;
        p6_q    <= PERMUT6_MAX;
        p7_q    <= PERMUT7_MAX;
        bot_q   <= bot_i;
        load_q  <= 1'b1;
      end else if (state_q == LaneRun) begin
        if (at_end) begin
          state_q <= LaneIdle;
          p6_q    <= 3'd0;
          p7_q    <= 3'd0;
        end else if (p7_q == 3'd0) begin
          p7_q <= PERMUT7_MAX;
          p6_q <= p6_q - 3'd1;
        end else begin
          p7_q   <= p7_q - 3'd1;
          // Flag the pulse so it lines up with the (0,0) index it belongs to.
          done_q <= (p6_q == 3'd0) && (p7_q == 3'd1);
        end
      end
    end
  end

  assign bot_o     = bot_q;
  assign permut6_o = p6_q;
  assign permut7_o = p7_q;
  assign load_o    = load_q;
  assign active_o  = (state_q == LaneRun);
  assign done_o    = done_q;

endmodule

// File: rtl/permutation_lane_scheduler.sv
// Distributes bots from a show-ahead input FIFO onto NUM_LANES independent permutation
// lanes. The FIFO head goes to one eligible lane per cycle, chosen round-robin.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   inputBot         : FIFO head data, valid with inputBotValid
//   inputBotValid    : FIFO head holds a bot
//   inputBotRead     : pop the FIFO head this cycle (combinational)
//   laneSlowDown     : per-lane block on accepting a new bot
//   laneBot          : per-lane bot, lane i at [i*128 +: 128]
//   lanePermut6/7    : per-lane index pair, lane i at [i*3 +: 3]
//   laneLoad         : per-lane new-bot pulse
//   laneActive       : per-lane valid
//   laneSeriesDone   : per-lane last-index pulse
//   busyCount        : number of active lanes (registered)
//   seriesCompleted  : wrapping count of finished series
module permutation_lane_scheduler
  import permutation_lane_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BOT_W-1:0]           inputBot,
  input  logic                       inputBotValid,
  output logic                       inputBotRead,
  input  logic [NUM_LANES-1:0]       laneSlowDown,
  output logic [BOT_W*NUM_LANES-1:0] laneBot,
  output logic [3*NUM_LANES-1:0]     lanePermut6,
  output logic [3*NUM_LANES-1:0]     lanePermut7,
  output logic [NUM_LANES-1:0]       laneLoad,
  output logic [NUM_LANES-1:0]       laneActive,
  output logic [NUM_LANES-1:0]       laneSeriesDone,
  output logic [2:0]                 busyCount,
  output logic [CNT_W-1:0]           seriesCompleted
);

  localparam int unsigned PtrW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0] active_next;
  logic [5:0]           active_pad;
  logic                 grant_any;
  logic                 hi_found;
  int                   hi_idx;
  int                   lo_idx;
  int                   win_idx;
  logic [2:0]           busy_count_q;
  logic [CNT_W-1:0]     series_cnt_q;

  // Round-robin pick: the lowest eligible lane at or above rr_ptr wins; failing that,
  // the lowest eligible lane overall (the wrap-around case).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 0;
    lo_idx   = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_idx = i;
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = i;
        end
      end
    end
    win_idx   = hi_found ? hi_idx : lo_idx;
    grant_any = inputBotValid && (|eligible);
    for (int i = 0; i < NUM_LANES; i++) begin
      grant[i] = grant_any && (win_idx == i);
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (win_idx == NUM_LANES - 1) ? '0 : PtrW'(win_idx + 1);
    end
  end

  assign inputBotRead = grant_any;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    permutation_lane_sequencer u_seq (
      .clk           (clk),
      .rst           (rst),
      .grant_i       (grant[i]),
      .slow_down_i   (laneSlowDown[i]),
      .bot_i         (inputBot),
      .eligible_o    (eligible[i]),
      .active_next_o (active_next[i]),
      .bot_o         (laneBot[i*BOT_W +: BOT_W]),
      .permut6_o     (lanePermut6[i*3 +: 3]),
      .permut7_o     (lanePermut7[i*3 +: 3]),
      .load_o        (laneLoad[i]),
      .active_o      (laneActive[i]),
      .done_o        (laneSeriesDone[i])
    );
  end

  always_comb begin
    active_pad                = '0;
    active_pad[NUM_LANES-1:0] = active_next;
  end

  // Counting next-state activity keeps busyCount aligned with laneActive.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      busy_count_q <= 3'd0;
      series_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      busy_count_q <= count_lanes(active_pad);
      series_cnt_q <= series_cnt_q + {{(CNT_W-1){1'b0}}, |laneSeriesDone};
    end
  end

  assign busyCount       = busy_count_q;
  assign seriesCompleted = series_cnt_q;

`ifndef SYNTHESIS
  // Single grant per cycle and fixed series length keep completions apart.
  a_one_done : assert property (@(posedge clk) disable iff (rst) $onehot0(laneSeriesDone))
    else $error("more than one laneSeriesDone in a cycle");
`endif

endmodule

// File: tb/tb_permutation_lane_scheduler.sv
module tb_permutation_lane_scheduler;

  localparam int NL = 4;
  localparam int CW = 32;

  logic           clk;
  logic           rst;
  logic [127:0]   inputBot;
  logic           inputBotValid;
  logic           inputBotRead;
  logic [NL-1:0]  laneSlowDown;
  logic [128*NL-1:0] laneBot;
  logic [3*NL-1:0] lanePermut6;
  logic [3*NL-1:0] lanePermut7;
  logic [NL-1:0]  laneLoad;
  logic [NL-1:0]  laneActive;
  logic [NL-1:0]  laneSeriesDone;
  logic [2:0]     busyCount;
  logic [CW-1:0]  seriesCompleted;

  permutation_lane_scheduler #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .inputBot        (inputBot),
    .inputBotValid   (inputBotValid),
    .inputBotRead    (inputBotRead),
    .laneSlowDown    (laneSlowDown),
    .laneBot         (laneBot),
    .lanePermut6     (lanePermut6),
    .lanePermut7     (lanePermut7),
    .laneLoad        (laneLoad),
    .laneActive      (laneActive),
    .laneSeriesDone  (laneSeriesDone),
    .busyCount       (busyCount),
    .seriesCompleted (seriesCompleted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a lane is either free or k cycles into its 42-cycle series.
  bit           m_busy[NL];
  int           m_k[NL];
  logic [127:0] m_bot[NL];
  bit           m_load[NL];
  int           m_rr;
  int unsigned  m_cnt;

  logic [127:0] fifo[$];
  bit           fifo_en;
  bit           obs_read;
  int           cyc;
  int           n_cmp;
  int           n_err;
  int           pops;
  int           loads;
  int           multi_done;

  typedef struct {
    int         off;
    logic [2:0] p6;
    logic [2:0] p7;
    logic       ld;
    logic       dn;
    logic       act;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mkv(int off, int p6, int p7, bit ld, bit dn, bit act);
    vec_t v;
    v.off = off; v.p6 = 3'(p6); v.p7 = 3'(p7); v.ld = ld; v.dn = dn; v.act = act;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_busy[i] = 0; m_k[i] = 0; m_bot[i] = '0; m_load[i] = 0;
    end
    m_rr  = 0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo.delete();
    fifo_en       = 1'b1;
    inputBotValid = 1'b0;
    inputBot      = '0;
    laneSlowDown  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cyc   = 0;
    pops  = 0;
    loads = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " active"}, 128'(laneActive), 128'(0));
    chk({tag, " load"}, 128'(laneLoad), 128'(0));
    chk({tag, " done"}, 128'(laneSeriesDone), 128'(0));
    chk({tag, " p6"}, 128'(lanePermut6), 128'(0));
    chk({tag, " p7"}, 128'(lanePermut7), 128'(0));
    chk({tag, " bots"}, 128'(|laneBot), 128'(0));
    chk({tag, " busy"}, 128'(busyCount), 128'(0));
    chk({tag, " cnt"}, 128'(seriesCompleted), 128'(0));
    chk({tag, " read"}, 128'(inputBotRead), 128'(0));
  endtask

  // One clock cycle: present inputs, compare with the model, advance both.
  task automatic tick();
    logic [NL-1:0] e_act, e_load, e_done;
    int  bc;
    bit  elig[NL];
    bit  exp_read;
    int  win;
    inputBotValid = fifo_en && (fifo.size() > 0);
    inputBot      = inputBotValid ? fifo[0] : '0;
    #1;
    bc = 0;
    for (int i = 0; i < NL; i++) begin
      e_act[i]  = m_busy[i];
      e_load[i] = m_load[i];
      e_done[i] = m_busy[i] && (m_k[i] == 41);
      bc += m_busy[i] ? 1 : 0;
      chk($sformatf("bot%0d", i), laneBot[i*128 +: 128], m_bot[i]);
      chk($sformatf("p6_%0d", i), 128'(lanePermut6[i*3 +: 3]),
          128'(m_busy[i] ? 5 - m_k[i] / 7 : 0));
      chk($sformatf("p7_%0d", i), 128'(lanePermut7[i*3 +: 3]),
          128'(m_busy[i] ? 6 - m_k[i] % 7 : 0));
    end
    chk("active", 128'(laneActive), 128'(e_act));
    chk("load", 128'(laneLoad), 128'(e_load));
    chk("done", 128'(laneSeriesDone), 128'(e_done));
    chk("busyCount", 128'(busyCount), 128'(bc));
    chk("seriesCompleted", 128'(seriesCompleted), 128'(m_cnt));
    win = -1;
    for (int off = 0; off < NL; off++) begin
      int j;
      j = (m_rr + off) % NL;
      elig[j] = !laneSlowDown[j] && (!m_busy[j] || m_k[j] == 41);
      if (win < 0 && elig[j]) win = j;
    end
    exp_read = inputBotValid && (win >= 0);
    chk("inputBotRead", 128'(inputBotRead), 128'(exp_read));
    obs_read = inputBotRead;
    if ($countones(laneSeriesDone) > 1) multi_done++;
    if (inputBotRead) pops++;
    loads += $countones(laneLoad);
    if (rst) begin
      model_reset();
    end else begin
      if (|e_done) m_cnt++;
      for (int i = 0; i < NL; i++) begin
        m_load[i] = 0;
        if (exp_read && win == i) begin
          m_busy[i] = 1; m_k[i] = 0; m_bot[i] = inputBot; m_load[i] = 1;
        end else if (m_busy[i]) begin
          if (m_k[i] == 41) m_busy[i] = 0;
          else m_k[i]++;
        end
      end
      if (exp_read) m_rr = (win + 1) % NL;
    end
    if (inputBotRead && !rst) void'(fifo.pop_front());
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   order, nload, first_load, b4_cyc, b4_lane, busy_bad, act_cnt, distinct;
    int   l2cyc, l2act, bad, t0, pop_cyc, c;
    bit   seen[6][7];
    logic [127:0] bot_a;
    n_cmp = 0; n_err = 0; multi_done = 0;
    rst = 1'b1;
    fifo_en = 1'b1;
    inputBotValid = 1'b0;
    inputBot = '0;
    laneSlowDown = '0;

    // Single bot: index walk checked against a hand-derived table.
    tv.push_back(mkv(1, 5, 6, 1, 0, 1));
    tv.push_back(mkv(2, 5, 5, 0, 0, 1));
    tv.push_back(mkv(7, 5, 0, 0, 0, 1));
    tv.push_back(mkv(8, 4, 6, 0, 0, 1));
    tv.push_back(mkv(35, 1, 0, 0, 0, 1));
    tv.push_back(mkv(36, 0, 6, 0, 0, 1));
    tv.push_back(mkv(41, 0, 1, 0, 0, 1));
    tv.push_back(mkv(42, 0, 0, 0, 1, 1));
    tv.push_back(mkv(43, 0, 0, 0, 0, 0));

    do_reset();
    check_reset_state("reset");
    bot_a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    fifo.push_back(bot_a);
    tick();
    chk("single read at T", 128'(obs_read), 128'(1));
    act_cnt = 0;
    foreach (seen[a, b]) seen[a][b] = 0;
    for (int off = 1; off <= 43; off++) begin
      foreach (tv[v]) begin
        if (tv[v].off == off) begin
          chk($sformatf("single vec off %0d", off),
              128'({lanePermut6[2:0], lanePermut7[2:0], laneLoad[0], laneSeriesDone[0],
                    laneActive[0]}),
              128'({tv[v].p6, tv[v].p7, tv[v].ld, tv[v].dn, tv[v].act}));
        end
      end
      if (off == 1) chk("single laneBot", laneBot[127:0], bot_a);
      if (laneActive[0]) begin
        act_cnt++;
        if (lanePermut6[2:0] < 6 && lanePermut7[2:0] < 7)
          seen[lanePermut6[2:0]][lanePermut7[2:0]] = 1;
      end
      if (off < 43) tick();
    end
    distinct = 0;
    foreach (seen[a, b]) distinct += seen[a][b] ? 1 : 0;
    chk("single active cycles", 128'(act_cnt), 128'(42));
    chk("single distinct pairs", 128'(distinct), 128'(42));
    chk("single seriesCompleted", 128'(seriesCompleted), 128'(1));

    // Continuous FIFO: eight bots, round-robin and back-to-back reloads.
    do_reset();
    for (int j = 0; j < 8; j++) fifo.push_back(128'(32'hB000 + j));
    order = 0; nload = 0; first_load = -1; b4_cyc = -1; b4_lane = -1; busy_bad = 0;
    repeat (100) begin
      for (int i = 0; i < NL; i++) begin
        if (laneLoad[i]) begin
          if (nload < 8) order |= i << (4 * nload);
          if (nload == 4) begin b4_cyc = cyc; b4_lane = i; end
          if (first_load < 0) first_load = cyc;
          nload++;
        end
      end
      if (first_load >= 0 && cyc >= first_load + 3 && cyc <= first_load + 83 && busyCount != 3'd4)
        busy_bad++;
      tick();
    end
    chk("cont load order", 128'(order), 128'(32'h3210_3210));
    chk("cont load count", 128'(nload), 128'(8));
    chk("cont B4 lane", 128'(b4_lane), 128'(0));
    chk("cont B4 no gap", 128'(b4_cyc), 128'(first_load + 42));
    chk("cont busy steady", 128'(busy_bad), 128'(0));
    chk("cont seriesCompleted", 128'(seriesCompleted), 128'(8));

    // Lane 1 slowed throughout; lane 2 slowed mid-series.
    do_reset();
    laneSlowDown = 4'b0010;
    for (int j = 0; j < 3; j++) fifo.push_back(128'(32'hC000 + j));
    order = 0; nload = 0; l2cyc = -100; l2act = 0; bad = 0;
    repeat (60) begin
      for (int i = 0; i < NL; i++) begin
        if (laneLoad[i]) begin
          if (nload < 8) order |= i << (4 * nload);
          nload++;
        end
      end
      if (laneLoad[2]) l2cyc = cyc;
      if (cyc == l2cyc + 5) laneSlowDown[2] = 1'b1;
      if (laneActive[1]) bad++;
      if (laneActive[2]) l2act++;
      tick();
    end
    chk("slow load order", 128'(order), 128'(12'h320));
    chk("slow lane1 idle", 128'(bad), 128'(0));
    chk("slow lane2 length", 128'(l2act), 128'(42));
    laneSlowDown = '0;

    // Empty FIFO, then a bot arriving while every lane is mid-series.
    do_reset();
    bad = 0;
    repeat (100) begin
      tick();
      if (obs_read || laneActive != '0) bad++;
    end
    chk("empty idle", 128'(bad), 128'(0));
    for (int j = 0; j < 4; j++) fifo.push_back(128'(32'hD000 + j));
    t0 = cyc;
    repeat (4) tick();
    pop_cyc = -1;
    for (int n = 0; n < 100 && pop_cyc < 0; n++) begin
      if (cyc == t0 + 10) fifo.push_back(128'hD00D);
      c = cyc;
      tick();
      if (obs_read) pop_cyc = c;
    end
    chk("late bot pop cycle", 128'(pop_cyc), 128'(t0 + 42));

    // Reset in the middle of a series.
    do_reset();
    fifo.push_back(128'hE0);
    repeat (21) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midreset");
    fifo.push_back(128'hE1);
    tick();
    chk("midreset read", 128'(obs_read), 128'(1));
    chk("midreset lane0 load", 128'(laneLoad), 128'(4'b0001));

    // Random valid/slowdown stress against the model.
    do_reset();
    multi_done = 0;
    repeat (3000) begin
      laneSlowDown = 4'($urandom);
      fifo_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fifo.size() < 8)
        fifo.push_back({$urandom, $urandom, $urandom, $urandom});
      tick();
    end
    fifo_en = 1'b0;
    laneSlowDown = '0;
    repeat (60) tick();
    chk("rand one done per cycle", 128'(multi_done), 128'(0));
    chk("rand pops vs loads", 128'(pops), 128'(loads));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
